// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_scanner: 4x4 matrix keypad column scanner with debounced hex code |
// | Optional auto-repeat strobe under macro KEYPAD_REPEAT_EN.  Rev 1.0       |
// +--------------------------------------------------------------------------+
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DWELL_W  = $clog2(SCAN_CYCLES) + 1;
  localparam int STABLE_W = $clog2(DEBOUNCE_SCANS) + 1;
  localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
  localparam logic [DWELL_W-1:0]  DWELL_ONE  = DWELL_W'(1);
  localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(DEBOUNCE_SCANS);
  localparam logic [STABLE_W-1:0] STABLE_ONE = STABLE_W'(1);

  generate
    if (SCAN_CYCLES < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
      $error("keypad_scanner: parameter below its minimum");
    end
  endgenerate

  // Map index is col*4+row; the table follows the printed keypad legend.
  function automatic logic [3:0] key_hex(input logic [3:0] idx);
    case (idx)
      4'd0:  key_hex = 4'h1;  4'd1:  key_hex = 4'h4;
      4'd2:  key_hex = 4'h7;  4'd3:  key_hex = 4'h0;
      4'd4:  key_hex = 4'h2;  4'd5:  key_hex = 4'h5;
      4'd6:  key_hex = 4'h8;  4'd7:  key_hex = 4'hF;
      4'd8:  key_hex = 4'h3;  4'd9:  key_hex = 4'h6;
      4'd10: key_hex = 4'h9;  4'd11: key_hex = 4'hE;
      4'd12: key_hex = 4'hA;  4'd13: key_hex = 4'hB;
      4'd14: key_hex = 4'hC;  default: key_hex = 4'hD;
    endcase
  endfunction

  logic [3:0]          row_meta_q, row_meta_d;
  logic [3:0]          row_sync_q, row_sync_d;
  logic [3:0]          col_q, col_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [15:0]         map_q, map_d;
  logic [4:0]          result_q, result_d;   // {found, hex}
  logic [STABLE_W-1:0] stable_q, stable_d;
  logic                eval_q, eval_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_down_q, key_down_d;
  logic                key_valid_q, key_valid_d;

  logic                dwell_last;
  logic                scan_end;
  logic                scan_found;
  logic [3:0]          scan_code;
  logic [4:0]          scan_result;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_SCANS) + 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_SCANS - 1);
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_fire_q, rpt_fire_d;
`endif

  always_comb begin
    row_meta_d  = row;
    row_sync_d  = row_meta_q;
    col_d       = col_q;
    col_idx_d   = col_idx_q;
    dwell_d     = dwell_q + DWELL_ONE;
    map_d       = map_q;
    result_d    = result_q;
    stable_d    = stable_q;
    eval_d      = 1'b0;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;
    key_valid_d = 1'b0;

    dwell_last = (dwell_q == DWELL_LAST);
    scan_end   = dwell_last && (col_idx_q == 2'd3);

    if (dwell_last) begin
      dwell_d   = '0;
      col_d     = {col_q[2:0], col_q[3]};
      col_idx_d = col_idx_q + 2'd1;
      map_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
    end

    // Descending sweep so the lowest pressed index wins.
    scan_found = 1'b0;
    scan_code  = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (map_d[i]) begin
        scan_found = 1'b1;
        scan_code  = key_hex(4'(i));
      end
    end
    scan_result = {scan_found, scan_code};

    if (scan_end) begin
      result_d = scan_result;
      if (scan_result != result_q) begin
        stable_d = STABLE_ONE;
        eval_d   = (STABLE_ONE == STABLE_MAX);
      end else if (stable_q != STABLE_MAX) begin
        stable_d = stable_q + STABLE_ONE;
        eval_d   = (stable_d == STABLE_MAX);
      end
    end

    // Commit runs one cycle after the scan that made the result stable.
    if (eval_q) begin
      if (result_q[4]) begin
        if (!key_down_q || (result_q[3:0] != key_code_q)) begin
          key_code_d  = result_q[3:0];
          key_down_d  = 1'b1;
          key_valid_d = 1'b1;
        end
      end else begin
        key_down_d = 1'b0;
      end
    end

`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_d  = rpt_cnt_q;
    rpt_fire_d = 1'b0;
    if (scan_end) begin
      if (key_down_q && scan_found && (scan_code == key_code_q)) begin
        if (rpt_cnt_q == RPT_LAST) begin
          rpt_cnt_d  = '0;
          rpt_fire_d = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
      end else begin
        rpt_cnt_d = '0;
      end
    end
    if (rpt_fire_q) begin
      key_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q  <= 4'b1111;
      row_sync_q  <= 4'b1111;
      col_q       <= 4'b1110;
      col_idx_q   <= 2'd0;
      dwell_q     <= '0;
      map_q       <= '0;
      result_q    <= '0;
      stable_q    <= '0;
      eval_q      <= 1'b0;
      key_code_q  <= 4'h0;
      key_down_q  <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      col_q       <= col_d;
      col_idx_q   <= col_idx_d;
      dwell_q     <= dwell_d;
      map_q       <= map_d;
      result_q    <= result_d;
      stable_q    <= stable_d;
      eval_q      <= eval_d;
      key_code_q  <= key_code_d;
      key_down_q  <= key_down_d;
      key_valid_q <= key_valid_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q  <= '0;
      rpt_fire_q <= 1'b0;
    end else begin
      rpt_cnt_q  <= rpt_cnt_d;
      rpt_fire_q <= rpt_fire_d;
    end
  end
`endif

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule
`default_nettype wire
